// File: rtl/ble_tx_bit_serializer_pkg.sv
// rtl/ble_tx_bit_serializer_pkg.sv - shared types and constants for the BLE TX bit serializer
// Purpose: state encoding, field lengths, CRC24 polynomial and CRC step helper.
// Ports: none (package).
package ble_tx_bit_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ACCESS,
    ST_PDU,
    ST_CRC
  } state_t;

  localparam logic [23:0] CRC24_POLY   = 24'h00065B;
  localparam int          PREAMBLE_LEN = 8;
  localparam int          AA_LEN       = 32;
  localparam int          CRC_LEN      = 24;
  localparam int          MAX_LEN_DEF  = 37;

  // Last bit index of each fixed field, sized for the 5-bit field counter.
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] AA_LAST  = 5'(AA_LEN - 1);
  localparam logic [4:0] CRC_LAST = 5'(CRC_LEN - 1);

  // One CRC24 LFSR step: feedback is the register MSB xor the incoming data bit.
  function automatic logic [23:0] crc24_next(input logic [23:0] crc, input logic din);
    logic fb;
    fb = crc[23] ^ din;
    return {crc[22:0], 1'b0} ^ (fb ? CRC24_POLY : 24'h000000);
  endfunction

endpackage

// File: rtl/ble_crc24_whiten.sv
// rtl/ble_crc24_whiten.sv - CRC24 and data whitening LFSRs for the BLE link layer
// Purpose: holds the CRC24 register and the x^7+x^4+1 whitening LFSR.
// Whitening LFSR is built only when BLE_WHITEN_EN is defined; otherwise the
// whitening outputs are constant 0.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_load             preset CRC to CRC_INIT and LFSR to WHITEN_INIT
//   i_crc_step         advance CRC with i_crc_bit
//   i_crc_bit          unwhitened data bit fed to the CRC
//   i_wht_step         advance whitening LFSR one bit
//   o_crc              current CRC register
//   o_crc_msb_next     MSB the CRC would have after stepping with i_crc_bit
//   o_wht_bit          current whitening bit
//   o_wht_next         whitening bit after one more step
module ble_crc24_whiten
  import ble_tx_bit_serializer_pkg::*;
#(
  parameter logic [23:0] CRC_INIT    = 24'h555555,
  parameter logic [6:0]  WHITEN_INIT = 7'h65
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_crc_step,
  input  logic        i_crc_bit,
  input  logic        i_wht_step,
  output logic [23:0] o_crc,
  output logic        o_crc_msb_next,
  output logic        o_wht_bit,
  output logic        o_wht_next
);

  logic [23:0] r_crc;
  logic [23:0] w_crc_next;

  assign w_crc_next     = crc24_next(r_crc, i_crc_bit);
  assign o_crc          = r_crc;
  assign o_crc_msb_next = w_crc_next[23];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= 24'h000000;
    end else if (i_load) begin
      r_crc <= CRC_INIT;
    end else if (i_crc_step) begin
      r_crc <= w_crc_next;
    end
  end

`ifdef BLE_WHITEN_EN
  logic [6:0] r_lfsr;
  logic [6:0] w_lfsr_next;

  // Output tap is bit 6; it recirculates into bit 0 and is xored into bit 4.
  assign w_lfsr_next = {r_lfsr[5:4], r_lfsr[3] ^ r_lfsr[6], r_lfsr[2:0], r_lfsr[6]};
  assign o_wht_bit   = r_lfsr[6];
  assign o_wht_next  = w_lfsr_next[6];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 7'h00;
    end else if (i_load) begin
      r_lfsr <= WHITEN_INIT;
    end else if (i_wht_step) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  logic w_unused_whiten;
  assign w_unused_whiten = ^{WHITEN_INIT, i_wht_step};
  assign o_wht_bit       = 1'b0;
  assign o_wht_next      = 1'b0;
`endif

endmodule

// File: rtl/ble_tx_bit_serializer.sv
// rtl/ble_tx_bit_serializer.sv - BLE link-layer packet to serial bit stream for the FSK modulator
// Purpose: sends preamble, access address, PDU and CRC24 one bit per i_sym_done.
// PDU and CRC are whitened when BLE_WHITEN_EN is defined.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_tx_req, i_pdu_len       start pulse and PDU byte count (sampled in IDLE)
//   i_byte_data, i_byte_valid PDU byte source; o_byte_ready accepts a byte
//   i_sym_done                modulator pulse: current symbol ends
//   o_sym_val, o_mod_enable   bit and enable to the modulator
//   o_busy                    packet in progress
//   o_tx_done, o_tx_err       one-cycle completion / abort pulses
module ble_tx_bit_serializer
  import ble_tx_bit_serializer_pkg::*;
#(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter logic [23:0] CRC_INIT    = 24'h555555,
  parameter logic [6:0]  WHITEN_INIT = 7'h65,
  parameter int          MAX_LEN     = MAX_LEN_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_req,
  input  logic [5:0] i_pdu_len,
  input  logic [7:0] i_byte_data,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic       i_sym_done,
  output logic       o_sym_val,
  output logic       o_mod_enable,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_err
);

  state_t      r_state;
  logic [4:0]  r_bit_cnt;
  logic [5:0]  r_byte_cnt;
  logic [5:0]  r_len;
  logic [5:0]  r_fetch_cnt;
  logic [7:0]  r_hold;
  logic        r_hold_vld;
  logic [7:0]  r_shift;
  logic        r_sym_val;
  logic        r_mod_en;
  logic        r_busy;
  logic        r_tx_done;
  logic        r_tx_err;

  logic        w_advance;
  logic        w_len_bad;
  logic        w_start;
  logic        w_byte_fire;
  logic        w_last_byte;
  logic [4:0]  w_crc_idx;
  logic [23:0] w_crc;
  logic        w_crc_msb_next;
  logic        w_wht_bit;
  logic        w_wht_next;

  assign w_advance   = i_sym_done && r_busy;
  assign w_len_bad   = (i_pdu_len == 6'd0) || (i_pdu_len > 6'(MAX_LEN));
  assign w_start     = (r_state == ST_IDLE) && i_tx_req && !w_len_bad;
  assign w_byte_fire = i_byte_valid && o_byte_ready;
  assign w_last_byte = (r_byte_cnt + 6'd1) == r_len;
  // Index of the CRC bit after the current one; only used while r_bit_cnt < CRC_LAST.
  assign w_crc_idx   = 5'd22 - r_bit_cnt;

  assign o_byte_ready = ((r_state == ST_ACCESS) || (r_state == ST_PDU)) &&
                        !r_hold_vld && (r_fetch_cnt != 6'd0);
  assign o_sym_val    = r_sym_val;
  assign o_mod_enable = r_mod_en;
  assign o_busy       = r_busy;
  assign o_tx_done    = r_tx_done;
  assign o_tx_err     = r_tx_err;

  ble_crc24_whiten #(
    .CRC_INIT   (CRC_INIT),
    .WHITEN_INIT(WHITEN_INIT)
  ) u_crc_whiten (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_load        (w_start),
    .i_crc_step    (w_advance && (r_state == ST_PDU)),
    .i_crc_bit     (r_shift[0]),
    .i_wht_step    (w_advance && ((r_state == ST_PDU) || (r_state == ST_CRC))),
    .o_crc         (w_crc),
    .o_crc_msb_next(w_crc_msb_next),
    .o_wht_bit     (w_wht_bit),
    .o_wht_next    (w_wht_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_byte_cnt  <= 6'd0;
      r_len       <= 6'd0;
      r_fetch_cnt <= 6'd0;
      r_hold      <= 8'h00;
      r_hold_vld  <= 1'b0;
      r_shift     <= 8'h00;
      r_sym_val   <= 1'b0;
      r_mod_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
      r_tx_err    <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;

      // Ready is only high with the holding register empty, so this never
      // collides with a consume that clears r_hold_vld below.
      if (w_byte_fire) begin
        r_hold      <= i_byte_data;
        r_hold_vld  <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt - 6'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_tx_req) begin
            if (w_len_bad) begin
              r_tx_err <= 1'b1;
            end else begin
              r_len       <= i_pdu_len;
              r_fetch_cnt <= i_pdu_len;
              r_byte_cnt  <= 6'd0;
              r_bit_cnt   <= 5'd0;
              r_hold_vld  <= 1'b0;
              r_busy      <= 1'b1;
              r_mod_en    <= 1'b1;
              r_sym_val   <= ACCESS_ADDR[0];
              r_state     <= ST_PREAMBLE;
            end
          end
        end

        ST_PREAMBLE: begin
          if (w_advance) begin
            if (r_bit_cnt == PRE_LAST) begin
              r_bit_cnt <= 5'd0;
              r_sym_val <= ACCESS_ADDR[0];
              r_state   <= ST_ACCESS;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              // Next preamble bit flips relative to the current index parity.
              r_sym_val <= ACCESS_ADDR[0] ^ ~r_bit_cnt[0];
            end
          end
        end

        ST_ACCESS, ST_PDU: begin
          if (w_advance) begin
            if ((r_state == ST_ACCESS) && (r_bit_cnt != AA_LAST)) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_sym_val <= ACCESS_ADDR[r_bit_cnt + 5'd1];
            end else if ((r_state == ST_PDU) && (r_bit_cnt[2:0] != 3'd7)) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_shift   <= r_shift >> 1;
              r_sym_val <= r_shift[1] ^ w_wht_next;
            end else if ((r_state == ST_PDU) && w_last_byte) begin
              r_bit_cnt <= 5'd0;
              r_sym_val <= w_crc_msb_next ^ w_wht_next;
              r_state   <= ST_CRC;
            end else if (r_hold_vld) begin
              // Byte boundary: the first PDU bit uses the unstepped whitener.
              r_shift    <= r_hold;
              r_hold_vld <= 1'b0;
              r_bit_cnt  <= 5'd0;
              r_byte_cnt <= (r_state == ST_ACCESS) ? 6'd0 : r_byte_cnt + 6'd1;
              r_sym_val  <= r_hold[0] ^ ((r_state == ST_ACCESS) ? w_wht_bit : w_wht_next);
              r_state    <= ST_PDU;
            end else begin
              r_tx_err  <= 1'b1;
              r_busy    <= 1'b0;
              r_mod_en  <= 1'b0;
              r_sym_val <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end

        ST_CRC: begin
          if (w_advance) begin
            if (r_bit_cnt == CRC_LAST) begin
              r_tx_done <= 1'b1;
              r_busy    <= 1'b0;
              r_mod_en  <= 1'b0;
              r_sym_val <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_sym_val <= w_crc[w_crc_idx] ^ w_wht_next;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_tx_bit_serializer.sv
// tb/tb_ble_tx_bit_serializer.sv - self-checking bench for ble_tx_bit_serializer
module tb_ble_tx_bit_serializer;

  localparam logic [31:0] AA    = 32'h8E89BED6;
  localparam logic [23:0] CINIT = 24'h555555;
  localparam logic [6:0]  WINIT = 7'h65;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_req;
  logic [5:0] pdu_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       sym_done;
  logic       sym_val;
  logic       mod_enable;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ready_cnt = 0;

  bit         exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  ble_tx_bit_serializer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tx_req    (tx_req),
    .i_pdu_len   (pdu_len),
    .i_byte_data (byte_data),
    .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready),
    .i_sym_done  (sym_done),
    .o_sym_val   (sym_val),
    .o_mod_enable(mod_enable),
    .o_busy      (busy),
    .o_tx_done   (tx_done),
    .o_tx_err    (tx_err)
  );

  always @(posedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (byte_ready) ready_cnt++;
  end

  // Byte source: presents the head of src_q, pops it on handshake.
  initial begin
    bit fire;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      fire = byte_valid && byte_ready;
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      byte_valid = (src_q.size() > 0);
      byte_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wbit(input logic [6:0] w);
`ifdef BLE_WHITEN_EN
    return w[6];
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard model: pushes every expected sym_val bit for pkt[0:len-1].
  task automatic build_pkt(input int len);
    logic [23:0] crc;
    logic [6:0]  w;
    bit d, fb;
    crc = CINIT;
    w   = WINIT;
    for (int i = 0; i < 8; i++) exp_q.push_back(AA[0] ^ i[0]);
    for (int i = 0; i < 32; i++) exp_q.push_back(AA[i]);
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < 8; j++) begin
        d = pkt[k][j];
        exp_q.push_back(d ^ wbit(w));
        fb  = crc[23] ^ d;
        crc = crc << 1;
        if (fb) crc = crc ^ 24'h00065B;
        w = {w[5:0], w[6]};
        w[4] = w[4] ^ w[0];
      end
    end
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(crc[23 - i] ^ wbit(w));
      w = {w[5:0], w[6]};
      w[4] = w[4] ^ w[0];
    end
  endtask

  task automatic start(input logic [5:0] len);
    @(negedge clk);
    pdu_len = len;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
  endtask

  task automatic run_bits(input int n, input string tag);
    bit e;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(tag, {29'd0, busy, mod_enable, sym_val}, {29'd0, 1'b1, 1'b1, e});
      end
      sym_done = 1'b1;
      @(negedge clk);
      sym_done = 1'b0;
    end
  endtask

  initial begin
    int d0, e0, r0;
    rst_n    = 1'b0;
    tx_req   = 1'b0;
    pdu_len  = 6'd0;
    sym_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, sym_val, mod_enable, busy, byte_ready, tx_done, tx_err}, 32'd0);
    rst_n = 1'b1;

    // sym_done while idle is ignored
    @(negedge clk);
    sym_done = 1'b1;
    @(negedge clk);
    sym_done = 1'b0;
    check("idle_sym_done", {29'd0, sym_val, busy, mod_enable}, 32'd0);

    // Reset mid-preamble
    pkt = '{8'h00, 8'h00};
    src_q = '{8'h00, 8'h00};
    build_pkt(2);
    start(6'd2);
    run_bits(3, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {26'd0, sym_val, mod_enable, busy, byte_ready, tx_done, tx_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();

    // Two zero bytes: full 80-bit packet
    d0 = done_cnt;
    e0 = err_cnt;
    pkt = '{8'h00, 8'h00};
    src_q = '{8'h00, 8'h00};
    build_pkt(2);
    start(6'd2);
    run_bits(80, "zero_pkt");
    check("zero_end", {28'd0, tx_done, busy, mod_enable, sym_val}, 32'b1000);
    @(negedge clk);
    check("zero_done_pulse", {31'd0, tx_done}, 32'd0);
    check("zero_done_cnt", done_cnt - d0, 32'd1);
    check("zero_err_cnt", err_cnt - e0, 32'd0);

    // Three bytes, with a tx_req injected mid-packet
    d0 = done_cnt;
    e0 = err_cnt;
    pkt = '{8'hA5, 8'h3C, 8'hF0};
    src_q = '{8'hA5, 8'h3C, 8'hF0};
    build_pkt(3);
    start(6'd3);
    run_bits(20, "busy_req_a");
    @(negedge clk);
    pdu_len = 6'd0;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
    run_bits(68, "busy_req_b");
    check("busy_req_end", {29'd0, tx_done, busy, exp_q.size() != 0}, 32'b100);
    @(negedge clk);
    check("busy_req_done_cnt", done_cnt - d0, 32'd1);
    check("busy_req_err_cnt", err_cnt - e0, 32'd0);

    // Underrun: only one of two bytes supplied
    d0 = done_cnt;
    pkt = '{8'h5A, 8'h00};
    src_q = '{8'h5A};
    build_pkt(2);
    start(6'd2);
    run_bits(48, "underrun");
    check("underrun_err", {29'd0, tx_err, busy, mod_enable}, 32'b100);
    exp_q.delete();
    @(negedge clk);
    check("underrun_err_pulse", {31'd0, tx_err}, 32'd0);
    repeat (5) @(negedge clk);
    check("underrun_no_done", done_cnt - d0, 32'd0);

    // Bad lengths
    src_q.delete();
    r0 = ready_cnt;
    start(6'd0);
    check("len0_err", {30'd0, tx_err, busy}, 32'b10);
    @(negedge clk);
    check("len0_err_pulse", {31'd0, tx_err}, 32'd0);
    start(6'd38);
    check("len38_err", {30'd0, tx_err, busy}, 32'b10);
    @(negedge clk);
    check("len38_idle", {30'd0, tx_err, busy}, 32'd0);
    check("badlen_no_ready", ready_cnt - r0, 32'd0);

    // Maximum length packet
    d0 = done_cnt;
    e0 = err_cnt;
    pkt.delete();
    for (int i = 0; i < 37; i++) pkt.push_back(8'($urandom_range(0, 255)));
    src_q = pkt;
    build_pkt(37);
    start(6'd37);
    run_bits(360, "max_pkt");
    check("max_end", {30'd0, tx_done, busy}, 32'b10);
    @(negedge clk);
    check("max_done_cnt", done_cnt - d0, 32'd1);
    check("max_err_cnt", err_cnt - e0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
